// File: rtl/timer_counter_pkg.sv
// Shared constants for the memory-mapped down-counter timer: register map,
// CTRL bit layout, mode codes, FSM encodings and per-instance base addresses.
package timer_counter_pkg;

  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_PRESET = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;

  localparam int unsigned CTRL_EN      = 0;
  localparam int unsigned CTRL_MODE_LO = 1;
  localparam int unsigned CTRL_MODE_HI = 2;
  localparam int unsigned CTRL_IM      = 3;

  localparam logic [1:0] MODE_ONESHOT  = 2'b00;
  localparam logic [1:0] MODE_PERIODIC = 2'b01;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_CNT  = 2'd2;
  localparam logic [1:0] ST_INT  = 2'd3;

  localparam logic [15:0] TC0_BASE = 16'h7f00;
  localparam logic [15:0] TC1_BASE = 16'h7f10;

  typedef struct packed {
    logic       im;
    logic [1:0] mode;
    logic       en;
  } ctrl_t;

endpackage

// File: rtl/timer_counter_if.sv
// Word-offset register bus between the address bridge and one timer instance.
interface timer_counter_if;
  logic [3:2]  addr;
  logic        we;
  logic [31:0] din;
  logic [31:0] dout;
  logic        irq;

  modport master (output addr, we, din, input dout, irq);
  modport slave  (input addr, we, din, output dout, irq);
endinterface

// File: rtl/timer_counter.sv
// 32-bit down-counter timer with one-shot/periodic modes and a maskable
// interrupt line; registers are word-addressed through the bridge.
module timer_counter
  import timer_counter_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  timer_counter_if.slave  bus
);

  ctrl_t       ctrl_q,     ctrl_d;
  logic [31:0] preset_q,   preset_d;
  logic [31:0] count_q,    count_d;
  logic [1:0]  state_q,    state_d;
  logic        irq_flag_q, irq_flag_d;

  always_comb begin
    ctrl_d     = ctrl_q;
    preset_d   = preset_q;
    count_d    = count_q;
    state_d    = state_q;
    irq_flag_d = irq_flag_q;

    case (state_q)
      ST_IDLE: begin
        if (ctrl_q.en) begin
          state_d    = ST_LOAD;
          irq_flag_d = 1'b0;
        end
      end
      ST_LOAD: begin
        count_d = preset_q;
        state_d = ST_CNT;
      end
      ST_CNT: begin
        if (!ctrl_q.en) begin
          state_d = ST_IDLE;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          count_d    = '0;
          irq_flag_d = 1'b1;
          state_d    = ST_INT;
        end
      end
      default: begin
        if (ctrl_q.mode == MODE_PERIODIC) begin
          irq_flag_d = 1'b0;
          state_d    = ST_LOAD;
        end else begin
          ctrl_d.en = 1'b0;
          state_d   = ST_IDLE;
        end
      end
    endcase

    // FSM decisions above use the pre-write CTRL; a bus write then
    // overrides every CTRL bit, including the one-shot EN auto-clear.
    if (bus.we) begin
      case (bus.addr)
        OFF_CTRL: begin
          ctrl_d.en   = bus.din[CTRL_EN];
          ctrl_d.mode = bus.din[CTRL_MODE_HI:CTRL_MODE_LO];
          ctrl_d.im   = bus.din[CTRL_IM];
        end
        OFF_PRESET: preset_d = bus.din;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q     <= '0;
      preset_q   <= '0;
      count_q    <= '0;
      state_q    <= ST_IDLE;
      irq_flag_q <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      state_q    <= state_d;
      irq_flag_q <= irq_flag_d;
    end
  end

  always_comb begin
    case (bus.addr)
      OFF_CTRL:   bus.dout = {28'd0, ctrl_q};
      OFF_PRESET: bus.dout = preset_q;
      OFF_COUNT:  bus.dout = count_q;
      default:    bus.dout = '0;
    endcase
  end

  assign bus.irq = ctrl_q.im & irq_flag_q;

endmodule

// File: tb/tb_timer_counter.sv
// Self-checking bench for timer_counter: directed scenarios plus random bus
// traffic, compared every cycle against a behavioural model of the timer.
module tb_timer_counter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  timer_counter_if bus ();

  timer_counter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  typedef enum {P_IDLE, P_LOAD, P_RUN, P_INT} phase_e;

  bit          m_en, m_im, m_flag;
  bit [1:0]    m_mode;
  int unsigned m_preset, m_count;
  phase_e      m_phase = P_IDLE;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One clock edge of the timer, described from its register/FSM rules.
  task automatic model_step(input bit rst, input bit we, input bit [1:0] a, input bit [31:0] d);
    bit          n_en, n_flag;
    int unsigned n_count;
    phase_e      n_phase;
    if (rst) begin
      m_en = 0; m_im = 0; m_mode = 0; m_flag = 0;
      m_preset = 0; m_count = 0; m_phase = P_IDLE;
      return;
    end
    n_en = m_en; n_flag = m_flag; n_count = m_count; n_phase = m_phase;
    case (m_phase)
      P_IDLE: if (m_en) begin n_phase = P_LOAD; n_flag = 0; end
      P_LOAD: begin n_count = m_preset; n_phase = P_RUN; end
      P_RUN: begin
        if (!m_en)            n_phase = P_IDLE;
        else if (m_count > 1) n_count = m_count - 1;
        else begin n_count = 0; n_flag = 1; n_phase = P_INT; end
      end
      P_INT: begin
        if (m_mode == 2'b01) begin n_flag = 0; n_phase = P_LOAD; end
        else begin n_en = 0; n_phase = P_IDLE; end
      end
    endcase
    m_en = n_en; m_flag = n_flag; m_count = n_count; m_phase = n_phase;
    if (we && a == 2'd0) begin
      m_en = d[0]; m_mode = d[2:1]; m_im = d[3];
    end else if (we && a == 2'd1) begin
      m_preset = d;
    end
  endtask

  task automatic rd(input bit [1:0] a, output logic [31:0] v);
    bus.addr = a;
    #1;
    v = bus.dout;
  endtask

  task automatic verify_all();
    logic [31:0] v;
    logic [31:0] exp;
    for (int unsigned a = 0; a < 4; a++) begin
      rd(a[1:0], v);
      case (a)
        0:       exp = {28'd0, m_im, m_mode, m_en};
        1:       exp = m_preset;
        2:       exp = m_count;
        default: exp = 32'd0;
      endcase
      check($sformatf("rd%0d", a), v, exp);
    end
    check("irq", {31'd0, bus.irq}, {31'd0, m_im & m_flag});
  endtask

  task automatic cycle(input bit rst, input bit we, input bit [1:0] a, input bit [31:0] d);
    reset    = rst;
    bus.we   = we;
    bus.addr = a;
    bus.din  = d;
    model_step(rst, we, a, d);
    @(posedge clk);
    #1;
    reset  = 1'b0;
    bus.we = 1'b0;
    verify_all();
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) cycle(0, 0, 2'd0, 32'd0);
  endtask

  task automatic wr(input bit [1:0] a, input bit [31:0] d);
    cycle(0, 1, a, d);
  endtask

  task automatic expect_reg(input string tag, input bit [1:0] a, input logic [31:0] exp);
    logic [31:0] v;
    rd(a, v);
    check(tag, v, exp);
  endtask

  task automatic expect_irq(input string tag, input bit exp);
    check(tag, {31'd0, bus.irq}, {31'd0, exp});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit reached;
    reset = 1'b1; bus.we = 1'b0; bus.addr = 2'd0; bus.din = '0;

    // Reset: two cycles, everything reads zero.
    cycle(1, 0, 2'd0, 32'd0);
    cycle(1, 0, 2'd0, 32'd0);
    expect_reg("rst_ctrl", 2'd0, 32'd0);
    expect_reg("rst_count", 2'd2, 32'd0);
    expect_irq("rst_irq", 1'b0);

    // Writes to COUNT and the unmapped offset are ignored.
    wr(2'd2, 32'h1234);
    expect_reg("count_ro", 2'd2, 32'd0);
    wr(2'd3, 32'hdead_beef);
    expect_reg("off3_zero", 2'd3, 32'd0);

    // One-shot, PRESET=5, enable at edge t.
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);
    for (int unsigned k = 1; k <= 8; k++) begin
      idle(1);
      if (k == 2) expect_reg("os_cnt_t2", 2'd2, 32'd5);
      if (k == 6) expect_reg("os_cnt_t6", 2'd2, 32'd1);
      if (k == 7) begin
        expect_reg("os_cnt_t7", 2'd2, 32'd0);
        expect_irq("os_irq_t7", 1'b1);
      end
      if (k == 8) begin
        expect_reg("os_ctrl_t8", 2'd0, 32'h8);
        expect_irq("os_irq_t8", 1'b1);
      end
    end
    idle(2);
    expect_irq("os_irq_hold", 1'b1);
    wr(2'd0, 32'h9);
    idle(1);
    expect_irq("os_rearm_clr", 1'b0);
    idle(10);

    // Periodic, PRESET=3: model tracks every pulse.
    wr(2'd1, 32'd3);
    wr(2'd0, 32'hB);
    idle(20);
    wr(2'd0, 32'h0);
    idle(3);

    // Disable mid-count and re-enable.
    wr(2'd1, 32'd100);
    wr(2'd0, 32'h1);
    reached = 0;
    for (int unsigned i = 0; i < 200 && !reached; i++) begin
      idle(1);
      if (m_count == 50) reached = 1;
    end
    check("dis_reach50", {31'd0, reached}, 32'd1);
    wr(2'd0, 32'h0);
    expect_reg("dis_freeze", 2'd2, 32'd49);
    idle(3);
    expect_reg("dis_hold", 2'd2, 32'd49);
    expect_irq("dis_irq", 1'b0);
    wr(2'd0, 32'h1);
    idle(2);
    expect_reg("dis_reload", 2'd2, 32'd100);
    wr(2'd0, 32'h0);
    idle(2);

    // Masking with a pending flag.
    wr(2'd1, 32'd1);
    wr(2'd0, 32'h9);
    idle(4);
    expect_irq("msk_pend", 1'b1);
    wr(2'd0, 32'h0);
    expect_irq("msk_off", 1'b0);
    wr(2'd0, 32'h8);
    expect_irq("msk_on", 1'b1);

    // PRESET=0: irq three cycles after enable.
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h9);
    idle(2);
    expect_irq("p0_t2", 1'b0);
    idle(1);
    expect_irq("p0_t3", 1'b1);
    idle(2);

    // CTRL write colliding with the one-shot EN auto-clear.
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h9);
    idle(4);
    wr(2'd0, 32'hD);
    expect_reg("coll_ctrl", 2'd0, 32'hD);
    idle(3);
    wr(2'd0, 32'h0);
    idle(2);

    // Mid-operation reset.
    wr(2'd1, 32'd7);
    wr(2'd0, 32'hB);
    idle(4);
    cycle(1, 0, 2'd0, 32'd0);
    expect_reg("mrst_ctrl", 2'd0, 32'd0);
    expect_reg("mrst_preset", 2'd1, 32'd0);
    expect_reg("mrst_count", 2'd2, 32'd0);
    expect_irq("mrst_irq", 1'b0);

    // Random bus traffic.
    for (int unsigned i = 0; i < 600; i++) begin
      int unsigned r;
      r = $urandom_range(0, 99);
      if (r < 1)
        cycle(1, 0, 2'd0, 32'd0);
      else if (r < 8)
        wr(2'd0, {$urandom_range(0, 32'hffff), 12'd0, 4'($urandom_range(0, 15))});
      else if (r < 13)
        wr(2'd1, 32'($urandom_range(0, 8)));
      else if (r < 16)
        wr(2'($urandom_range(2, 3)), $urandom);
      else
        idle(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
